// File: rtl/sim_completion_monitor.sv
// End-of-test monitor: sequences harness reset, counts cycles and latches the pass/fail verdict.
// Optional progress watchdog enabled by defining SIM_MONITOR_STALL_EN.
module sim_completion_monitor #(
    parameter int N_CH         = 4,
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 8,
    parameter int STALL_CYCLES = 1024,
    parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CYCLE_W-1:0] cfg_max_cycles,
    input  logic [CYCLE_W-1:0] cfg_dump_start,
    input  logic               cfg_all_mode,
    input  logic [N_CH-1:0]    ch_success,
    input  logic [N_CH-1:0]    ch_failure,
    input  logic [N_CH-1:0]    ch_progress,
    output logic               harness_reset,
    output logic               dump_en,
    output logic               done,
    output logic               passed,
    output logic               failed,
    output logic [1:0]         fail_reason,
    output logic [CH_W-1:0]    fail_channel,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [N_CH-1:0]    success_seen
);
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_PASS, S_FAIL} state_t;

    state_t             state_reg, state_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [CYCLE_W-1:0] count_reg, count_next;
    logic [N_CH-1:0]    seen_reg, seen_next;
    logic [1:0]         reason_reg, reason_next;
    logic [CH_W-1:0]    chan_reg, chan_next;
    logic               dump_reg, dump_next;
    logic               hreset_reg, passed_reg, failed_reg, done_reg;
    logic [CH_W-1:0]    lowest_fail;
    logic               pass_cond, timeout_hit, stall_hit;

`ifdef SIM_MONITOR_STALL_EN
    localparam int IDLE_W = $clog2(STALL_CYCLES + 1);
    logic [IDLE_W-1:0] idle_reg, idle_next;
`else
    localparam int unused_stall_cycles = STALL_CYCLES;
    logic unused_progress;
    assign unused_progress = ^ch_progress;
`endif

    always_comb begin
        lowest_fail = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_failure[i]) lowest_fail = CH_W'(i);
        end
    end

    assign pass_cond   = cfg_all_mode ? (&(seen_reg | ch_success)) : (|ch_success);
    assign timeout_hit = (cfg_max_cycles != '0) && (count_reg >= cfg_max_cycles);

`ifdef SIM_MONITOR_STALL_EN
    assign stall_hit = (idle_reg >= IDLE_W'(STALL_CYCLES - 1)) && (ch_progress == '0);
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        count_next  = count_reg;
        seen_next   = seen_reg;
        reason_next = reason_reg;
        chan_next   = chan_reg;
        dump_next   = dump_reg;
`ifdef SIM_MONITOR_STALL_EN
        idle_next   = idle_reg;
`endif
        if (!done_reg) begin
            if (!(&count_reg)) count_next = count_reg + CYCLE_W'(1);
            if (count_reg >= cfg_dump_start) dump_next = 1'b1;
        end

        case (state_reg)
            S_HOLD: begin
                hold_next = hold_reg + HOLD_W'(1);
                if (hold_reg == HOLD_W'(RESET_CYCLES - 1)) state_next = S_RUN;
            end
            S_RUN: begin
                seen_next = seen_reg | ch_success;
`ifdef SIM_MONITOR_STALL_EN
                idle_next = (ch_progress != '0) ? '0 : idle_reg + IDLE_W'(1);
`endif
                // Priority: channel failure, timeout, stall, then pass.
                if (|ch_failure) begin
                    state_next  = S_FAIL;
                    reason_next = 2'd2;
                    chan_next   = lowest_fail;
                end else if (timeout_hit) begin
                    state_next  = S_FAIL;
                    reason_next = 2'd1;
                end else if (stall_hit) begin
                    state_next  = S_FAIL;
                    reason_next = 2'd3;
                end else if (pass_cond) begin
                    state_next  = S_PASS;
                end
                if (state_next != S_RUN) dump_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_HOLD;
            hold_reg   <= '0;
            count_reg  <= '0;
            seen_reg   <= '0;
            reason_reg <= '0;
            chan_reg   <= '0;
            dump_reg   <= 1'b0;
            hreset_reg <= 1'b1;
            passed_reg <= 1'b0;
            failed_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            count_reg  <= count_next;
            seen_reg   <= seen_next;
            reason_reg <= reason_next;
            chan_reg   <= chan_next;
            dump_reg   <= dump_next;
            hreset_reg <= (state_next == S_HOLD);
            passed_reg <= (state_next == S_PASS);
            failed_reg <= (state_next == S_FAIL);
            done_reg   <= (state_next == S_PASS) || (state_next == S_FAIL);
        end
    end

`ifdef SIM_MONITOR_STALL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) idle_reg <= '0;
        else       idle_reg <= idle_next;
    end
`endif

    assign harness_reset = hreset_reg;
    assign dump_en       = dump_reg;
    assign done          = done_reg;
    assign passed        = passed_reg;
    assign failed        = failed_reg;
    assign fail_reason   = reason_reg;
    assign fail_channel  = chan_reg;
    assign cycle_count   = count_reg;
    assign success_seen  = seen_reg;

endmodule

// File: tb/tb_sim_completion_monitor.sv
// Scoreboard bench for sim_completion_monitor: expected verdicts are queued when the
// triggering stimulus is driven and compared once the monitor reaches its terminal state.
module tb_sim_completion_monitor;
    localparam int N_CH = 4;
    localparam int CW   = 64;
    localparam int RC   = 8;
    localparam int SC   = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] cfg_max_cycles = '0;
    logic [CW-1:0] cfg_dump_start = '0;
    logic          cfg_all_mode = 1'b0;
    logic [3:0]    ch_success = '0;
    logic [3:0]    ch_failure = '0;
    logic [3:0]    ch_progress = '0;
    logic          harness_reset, dump_en, done, passed, failed;
    logic [1:0]    fail_reason;
    logic [1:0]    fail_channel;
    logic [CW-1:0] cycle_count;
    logic [3:0]    success_seen;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        passed;
        logic        failed;
        logic [1:0]  reason;
        logic [1:0]  chan;
        logic [63:0] count;
        logic [3:0]  seen;
        logic        chk_seen;
    } exp_t;
    exp_t sb[$];

    sim_completion_monitor #(
        .N_CH(N_CH), .CYCLE_W(CW), .RESET_CYCLES(RC), .STALL_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start),
        .cfg_all_mode(cfg_all_mode),
        .ch_success(ch_success), .ch_failure(ch_failure), .ch_progress(ch_progress),
        .harness_reset(harness_reset), .dump_en(dump_en), .done(done),
        .passed(passed), .failed(failed), .fail_reason(fail_reason),
        .fail_channel(fail_channel), .cycle_count(cycle_count),
        .success_seen(success_seen)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hreset"}, 64'(harness_reset), 64'd1);
        check_val({tag, "_flags"}, {59'd0, done, passed, failed, dump_en, 1'b0}, 64'd0);
        check_val({tag, "_reason"}, {60'd0, fail_reason, fail_channel}, 64'd0);
        check_val({tag, "_count"}, cycle_count, 64'd0);
        check_val({tag, "_seen"}, 64'(success_seen), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_count(input logic [63:0] n);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (cycle_count == n) return;
        end
        check_val("wait_count_timeout", cycle_count, n);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            if (done) return;
            @(negedge clock);
        end
        check_val("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic push_exp(input string tag, input logic p, input logic f, input logic [1:0] r,
                            input logic [1:0] c, input logic [63:0] cnt, input logic [3:0] s,
                            input logic cs);
        exp_t e;
        e.tag = tag; e.passed = p; e.failed = f; e.reason = r; e.chan = c;
        e.count = cnt; e.seen = s; e.chk_seen = cs;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        wait_done();
        repeat (3) @(negedge clock);
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        $display("txn %s: passed=%0d failed=%0d reason=%0d chan=%0d count=%0d seen=%b dump=%0d",
                 e.tag, passed, failed, fail_reason, fail_channel, cycle_count, success_seen, dump_en);
        check_val({e.tag, "_done"}, 64'(done), 64'd1);
        check_val({e.tag, "_passed"}, 64'(passed), 64'(e.passed));
        check_val({e.tag, "_failed"}, 64'(failed), 64'(e.failed));
        check_val({e.tag, "_reason"}, 64'(fail_reason), 64'(e.reason));
        if (e.failed && e.reason == 2'd2)
            check_val({e.tag, "_chan"}, 64'(fail_channel), 64'(e.chan));
        check_val({e.tag, "_count"}, cycle_count, e.count);
        check_val({e.tag, "_dump"}, 64'(dump_en), 64'd0);
        if (e.chk_seen) check_val({e.tag, "_seen"}, 64'(success_seen), 64'(e.seen));
    endtask

    initial begin
        // Any-mode pass; a failure held through HOLD must be ignored.
        cfg_all_mode = 1'b0; cfg_max_cycles = '0; cfg_dump_start = '0;
        ch_failure = 4'b0001;
        do_reset();
        wait_count(7);
        check_val("hold_hreset_at7", 64'(harness_reset), 64'd1);
        check_val("dump_in_hold", 64'(dump_en), 64'd1);
        wait_count(8);
        check_val("run_hreset_at8", 64'(harness_reset), 64'd0);
        check_val("hold_ignores_fail", 64'(done), 64'd0);
        ch_failure = '0;
        wait_count(20);
        ch_success = 4'b0100;
        push_exp("any_pass", 1, 0, 0, 0, 64'd21, 4'b0100, 1);
        @(negedge clock);
        ch_success = '0;
        pop_compare();

        // All-mode with staggered single-cycle pulses.
        cfg_all_mode = 1'b1;
        do_reset();
        wait_count(15); ch_success = 4'b0001; @(negedge clock); ch_success = '0;
        wait_count(30); ch_success = 4'b0010; @(negedge clock);
        ch_success = 4'b0100; @(negedge clock); ch_success = '0;
        wait_count(40);
        check_val("all_early_pass", 64'(done), 64'd0);
        check_val("all_seen_partial", 64'(success_seen), 64'h7);
        ch_success = 4'b1000;
        push_exp("all_pass", 1, 0, 0, 0, 64'd41, 4'hF, 1);
        @(negedge clock);
        ch_success = '0;
        pop_compare();

        // Timeout with no channel activity.
        cfg_all_mode = 1'b0; cfg_max_cycles = 64'd100;
        do_reset();
        push_exp("timeout", 0, 1, 2'd1, 0, 64'd101, 4'h0, 1);
        wait_count(99);
        check_val("timeout_early", 64'(failed), 64'd0);
        pop_compare();

        // Failure and success on the same edge.
        cfg_all_mode = 1'b1; cfg_max_cycles = '0;
        do_reset();
        wait_count(50);
        ch_failure = 4'b1010; ch_success = 4'hF;
        push_exp("fail_over_pass", 0, 1, 2'd2, 2'd1, 64'd51, 4'h0, 0);
        @(negedge clock);
        ch_failure = '0; ch_success = '0;
        pop_compare();

        // Dump window and mid-test asynchronous reset, then clean restart.
        cfg_all_mode = 1'b0; cfg_dump_start = 64'd30;
        do_reset();
        wait_count(29);
        check_val("dump_before_start", 64'(dump_en), 64'd0);
        wait_count(32);
        check_val("dump_after_start", 64'(dump_en), 64'd1);
        wait_count(60);
        reset = 1'b1;
        #1;
        check_reset_outputs("midtest_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_count(12);
        check_val("restart_running", 64'(done), 64'd0);
        ch_success = 4'b1000;
        push_exp("restart_pass", 1, 0, 0, 0, 64'd13, 4'b1000, 1);
        @(negedge clock);
        ch_success = '0;
        pop_compare();

`ifdef SIM_MONITOR_STALL_EN
        // Progress watchdog restarted by one heartbeat.
        cfg_dump_start = '0;
        ch_progress = '0;
        do_reset();
        wait_count(18);
        ch_progress = 4'b0010;
        @(negedge clock);
        ch_progress = '0;
        push_exp("stall", 0, 1, 2'd3, 0, 64'd35, 4'h0, 1);
        wait_count(30);
        check_val("stall_restarted", 64'(failed), 64'd0);
        pop_compare();
`endif

        check_val("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
